// File: rtl/minn_delay_ctrl_pkg.sv
// Shared types and helpers for the Minn delay-memory controller.
package minn_pkg;
    typedef enum logic [1:0] {IDLE, FLUSH, PRIME, RUN} minn_dly_state_t;

    localparam int DROP_CNT_W = 16;

    function automatic int depth_w(input int max);
        return $clog2(max + 1);
    endfunction
endpackage

// File: rtl/minn_delay_ctrl_if.sv
// Sample stream in, aligned (current, delayed) pair out.
interface minn_delay_ctrl_if #(
    parameter int WIDTH = 16
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_cur;
    logic signed [WIDTH-1:0] out_dly;

    modport master (output in_valid, in_data, input in_ready, out_valid, out_cur, out_dly);
    modport slave  (input in_valid, in_data, output in_ready, out_valid, out_cur, out_dly);
endinterface

// File: rtl/minn_delay_ram.sv
// Single-address delay memory, synchronous read-first; storage is not reset.
module minn_delay_ram #(
    parameter int  WIDTH     = 16,
    parameter int  MAX_DEPTH = 64,
    localparam int AW        = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic                    re,
    input  logic [AW-1:0]           addr,
    input  logic signed [WIDTH-1:0] wdata,
    output logic signed [WIDTH-1:0] rdata
);
    logic signed [WIDTH-1:0] mem [MAX_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // Read register is cleared so the delayed output reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/minn_delay_ctrl.sv
// Minn delay sequencer: flush to zero, prime with depth samples, then emit pairs.
// Optional build macro MINN_DELAY_CTRL_STATS_EN adds the drop_cnt output.
module minn_delay_ctrl
    import minn_pkg::*;
#(
    parameter int  WIDTH     = 16,
    parameter int  MAX_DEPTH = 64,
    localparam int DW        = depth_w(MAX_DEPTH),
    localparam int AW        = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] cfg_depth,
    input  logic          cfg_load,
    input  logic          enable,
    minn_delay_ctrl_if.slave bus,
    output logic          primed,
    output logic          cfg_err
`ifdef MINN_DELAY_CTRL_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);

    minn_dly_state_t         state, state_n;
    logic [DW-1:0]           depth_q, wr_ptr, fill_cnt, fill_nxt;
    logic                    cfg_ok, acc, run_acc, wr_last;
    logic                    ram_we, ram_re;
    logic signed [WIDTH-1:0] ram_wdata, ram_rdata;

    assign bus.in_ready = (state == PRIME) || (state == RUN);
    assign primed       = (state == RUN);
    assign cfg_ok       = (cfg_depth != '0) && (cfg_depth <= MAX_D);
    assign acc          = bus.in_valid && bus.in_ready && !cfg_load && enable;
    assign run_acc      = acc && (state == RUN);
    assign wr_last      = (wr_ptr == depth_q - DW'(1));
    assign fill_nxt     = fill_cnt + DW'(1);
    assign bus.out_dly  = ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_wdata = '0;
        if (cfg_load) begin
            if (cfg_ok) state_n = FLUSH;
        end else if (!enable && state != IDLE) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (enable) state_n = FLUSH;
                FLUSH: begin
                    ram_we = 1'b1;
                    if (wr_last) state_n = PRIME;
                end
                PRIME: if (acc) begin
                    ram_we    = 1'b1;
                    ram_wdata = bus.in_data;
                    if (fill_nxt == depth_q) state_n = RUN;
                end
                RUN: if (acc) begin
                    ram_we    = 1'b1;
                    ram_re    = 1'b1;
                    ram_wdata = bus.in_data;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Pointer, fill count and output pair registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q       <= MAX_D;
            wr_ptr        <= '0;
            fill_cnt      <= '0;
            cfg_err       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_cur   <= '0;
        end else begin
            cfg_err       <= cfg_load && !cfg_ok;
            bus.out_valid <= run_acc;
            if (run_acc) bus.out_cur <= bus.in_data;
            if (cfg_load) begin
                if (cfg_ok) begin
                    depth_q  <= cfg_depth;
                    wr_ptr   <= '0;
                    fill_cnt <= '0;
                end
            end else if (state_n == IDLE) begin
                wr_ptr   <= '0;
                fill_cnt <= '0;
            end else if (ram_we) begin
                wr_ptr <= wr_last ? '0 : wr_ptr + DW'(1);
                if (state == PRIME)             fill_cnt <= fill_nxt;
                else if (state == FLUSH && wr_last) fill_cnt <= '0;
            end
        end
    end

`ifdef MINN_DELAY_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          drop_cnt <= '0;
        else if (cfg_load && cfg_ok)                         drop_cnt <= '0;
        else if (bus.in_valid && !acc && drop_cnt != '1)     drop_cnt <= drop_cnt + 1'b1;
    end
`endif

    minn_delay_ram #(
        .WIDTH     (WIDTH),
        .MAX_DEPTH (MAX_DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (wr_ptr[AW-1:0]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );
endmodule
